// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types and constants for the CPU pipeline boundary registers.
//   pipe_stage_state_t : occupancy state of a pipe_stage_reg instance
//   PIPE_STALL_CNT_W   : width of the saturating stall counter
//   id_ex_data_t / id_ex_ctrl_t : typical ID/EX payloads; their $bits() set
//   the default DATA_W / CTRL_W of pipe_stage_reg.
package cpu_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } pipe_stage_state_t;

  localparam int unsigned PIPE_STALL_CNT_W = 16;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] operand;
  } id_ex_data_t;

  typedef struct packed {
    logic [4:0] rd;
    logic [3:0] alu_op;
    logic       mem_rd;
    logic       mem_wr;
    logic       reg_wr;
    logic [3:0] rsvd;
  } id_ex_ctrl_t;

  localparam int unsigned PIPE_DATA_W = $bits(id_ex_data_t);
  localparam int unsigned PIPE_CTRL_W = $bits(id_ex_ctrl_t);

  // Number of valid entries held in a given state.
  function automatic logic [1:0] pipe_occupancy(input pipe_stage_state_t s);
    case (s)
      EMPTY:   return 2'd0;
      FULL:    return 2'd1;
      SKID:    return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_stage_slot.sv
// pipe_stage_slot: one valid + payload register entry.
// Ports:
//   clock, reset_n         : rising-edge clock, async active-low reset
//   load                   : capture load_data/load_ctrl and set valid
//   drop                   : clear valid, keep payload
//   clear                  : flush; clear valid and ctrl, and data when
//                            CLEAR_DATA_ON_FLUSH is set (priority over load)
//   load_data, load_ctrl   : payload to capture
//   valid, data, ctrl      : registered entry contents
module pipe_stage_slot #(
  parameter int unsigned DATA_W              = 64,
  parameter int unsigned CTRL_W              = 16,
  parameter bit          CLEAR_DATA_ON_FLUSH = 1'b1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              load,
  input  logic              drop,
  input  logic              clear,
  input  logic [DATA_W-1:0] load_data,
  input  logic [CTRL_W-1:0] load_ctrl,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic [CTRL_W-1:0] ctrl
);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid <= 1'b0;
      data  <= '0;
      ctrl  <= '0;
    end else if (clear) begin
      valid <= 1'b0;
      ctrl  <= '0;
      if (CLEAR_DATA_ON_FLUSH) data <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
      ctrl  <= load_ctrl;
    end else if (drop) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: parametrised pipeline boundary register with valid/ready
// handshake, flush-to-bubble and a saturating stall counter.
// Optional macro PIPE_STAGE_SKID_EN adds a skid entry: in_ready becomes a
// pure register output (no path from out_ready) and occupancy can reach 2.
// Ports:
//   clock, reset_n        : rising-edge clock, async active-low reset
//   in_valid/in_ready     : upstream handshake, in_data/in_ctrl payload
//   flush                 : kill held entries and any incoming beat
//   out_valid/out_ready   : downstream handshake, out_data/out_ctrl payload
//   occupancy             : number of valid entries (0..2)
//   stall_cnt             : saturating count of out_valid && !out_ready cycles
module pipe_stage_reg
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W              = PIPE_DATA_W,
  parameter int unsigned CTRL_W              = PIPE_CTRL_W,
  parameter bit          CLEAR_DATA_ON_FLUSH = 1'b1
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DATA_W-1:0]           in_data,
  input  logic [CTRL_W-1:0]           in_ctrl,
  input  logic                        flush,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_W-1:0]           out_data,
  output logic [CTRL_W-1:0]           out_ctrl,
  output logic [1:0]                  occupancy,
  output logic [PIPE_STALL_CNT_W-1:0] stall_cnt
);

  pipe_stage_state_t state, state_nxt;

  logic              in_xfer;
  logic              out_xfer;
  logic              main_valid;
  logic              main_load;
  logic              main_drop;
  logic [DATA_W-1:0] main_load_data;
  logic [CTRL_W-1:0] main_load_ctrl;

`ifdef PIPE_STAGE_SKID_EN
  logic              skid_valid;
  logic              skid_load;
  logic              skid_drop;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] skid_ctrl;
`endif

  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = main_valid && out_ready;
  assign out_valid = main_valid;

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= EMPTY;
    else          state <= state_nxt;
  end

  // Next-state logic; flush overrides every transition
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: if (in_xfer) state_nxt = FULL;
        FULL: begin
          if (out_xfer && !in_xfer) state_nxt = EMPTY;
`ifdef PIPE_STAGE_SKID_EN
          else if (in_xfer && !out_xfer) state_nxt = SKID;
`endif
        end
`ifdef PIPE_STAGE_SKID_EN
        SKID: if (out_xfer) state_nxt = FULL;
`endif
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // Output logic: ready and occupancy decoded from the state register
  always_comb begin
`ifdef PIPE_STAGE_SKID_EN
    in_ready = reset_n && (state != SKID);
`else
    in_ready = reset_n && ((state == EMPTY) || out_ready);
`endif
    occupancy = pipe_occupancy(state);
  end

  // Entry controls. In SKID the main entry refills from the skid entry so
  // the older beat always leaves first.
  always_comb begin
    main_load      = in_xfer && ((state == EMPTY) || ((state == FULL) && out_xfer));
    main_drop      = (state == FULL) && out_xfer && !in_xfer;
    main_load_data = in_data;
    main_load_ctrl = in_ctrl;
`ifdef PIPE_STAGE_SKID_EN
    skid_load = (state == FULL) && in_xfer && !out_xfer;
    skid_drop = (state == SKID) && out_xfer;
    if (state == SKID) begin
      main_load      = out_xfer;
      main_load_data = skid_data;
      main_load_ctrl = skid_ctrl;
    end
`endif
  end

  pipe_stage_slot #(
    .DATA_W              (DATA_W),
    .CTRL_W              (CTRL_W),
    .CLEAR_DATA_ON_FLUSH (CLEAR_DATA_ON_FLUSH)
  ) u_main (
    .clock     (clock),
    .reset_n   (reset_n),
    .load      (main_load),
    .drop      (main_drop),
    .clear     (flush),
    .load_data (main_load_data),
    .load_ctrl (main_load_ctrl),
    .valid     (main_valid),
    .data      (out_data),
    .ctrl      (out_ctrl)
  );

`ifdef PIPE_STAGE_SKID_EN
  pipe_stage_slot #(
    .DATA_W              (DATA_W),
    .CTRL_W              (CTRL_W),
    .CLEAR_DATA_ON_FLUSH (CLEAR_DATA_ON_FLUSH)
  ) u_skid (
    .clock     (clock),
    .reset_n   (reset_n),
    .load      (skid_load),
    .drop      (skid_drop),
    .clear     (flush),
    .load_data (in_data),
    .load_ctrl (in_ctrl),
    .valid     (skid_valid),
    .data      (skid_data),
    .ctrl      (skid_ctrl)
  );
`endif

  // Stall instrumentation; only reset clears it
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt <= '0;
    end else if (main_valid && !out_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule
